// File: rtl/axi_grid_router.sv
// ---------------------------------------------------------------------------
// axi_grid_router
//
// Three-port wormhole router node for a 2-D ring grid. Every input is
// buffered in a small FIFO holding {did, data, last}; each FIFO head is
// routed by a fixed column-first rule:
//   did.col != NI_COL -> H ring output (port 0)
//   did.row != NI_ROW -> V ring output (port 1)
//   otherwise         -> local output  (port 2)
// Each output arbitrates round-robin among the inputs requesting it. Once a
// beat is presented, the output locks to that input until the last beat of
// the packet is handed over, so packets never interleave.
//
// Optional feature: define AXI_GRID_ROUTER_STATS_EN to add per-output
// statistics counters (beat_cnt_o, stall_cnt_o). Without the macro these
// ports and their counters do not exist.
//
// Ports (index 0 = H ring, 1 = V ring, 2 = local):
//   clk_i        : single clock, rising edge
//   arst_ni      : asynchronous active-low reset
//   in_did_i     : destination {row, col} per input
//   in_data_i    : payload per input
//   in_last_i    : last beat of packet per input
//   in_valid_i   : input valid
//   in_ready_o   : input ready (FIFO not full, low while in reset)
//   out_did_o    : destination of the beat presented on each output
//   out_data_o   : payload presented on each output
//   out_last_o   : last flag presented on each output
//   out_valid_o  : output valid
//   out_ready_i  : output ready
//   beat_cnt_o   : (stats only) output handshakes, wraps at 2^32
//   stall_cnt_o  : (stats only) cycles with valid && !ready, wraps at 2^32
// ---------------------------------------------------------------------------
module axi_grid_router #(
  parameter int DATA_W     = 64,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2,
  parameter int NI_ROW     = 0,
  parameter int NI_COL     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [ROW_W+COL_W-1:0] in_did_i    [3],
  input  logic [DATA_W-1:0]      in_data_i   [3],
  input  logic                   in_last_i   [3],
  input  logic                   in_valid_i  [3],
  output logic                   in_ready_o  [3],
  output logic [ROW_W+COL_W-1:0] out_did_o   [3],
  output logic [DATA_W-1:0]      out_data_o  [3],
  output logic                   out_last_o  [3],
  output logic                   out_valid_o [3],
  input  logic                   out_ready_i [3]
`ifdef AXI_GRID_ROUTER_STATS_EN
  ,
  output logic [31:0]            beat_cnt_o  [3],
  output logic [31:0]            stall_cnt_o [3]
`endif
);

  localparam int DID_W   = ROW_W + COL_W;
  localparam int ENTRY_W = DID_W + DATA_W + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Entry layout: {did, data, last}; last in bit 0.
  logic [ENTRY_W-1:0] head       [3];
  logic               head_valid [3];
  logic [1:0]         dest       [3];
  logic               pop        [3];
  logic [1:0]         grant      [3];

  // Keeps every in_ready_o low while in reset; rises on the first clock
  // edge after release.
  logic ready_en_reg;

  // (base + k) mod 3 for base in 0..2, k in 0..2.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Input FIFOs and routing of their heads
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push;
    logic [COL_W-1:0]   head_col;
    logic [ROW_W-1:0]   head_row;

    assign in_ready_o[gi] = ready_en_reg && (count_reg != CNT_W'(FIFO_DEPTH));
    assign push           = in_valid_i[gi] && in_ready_o[gi];

    // Storage carries no reset; emptiness is tracked by the count.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr_reg] <= {in_did_i[gi], in_data_i[gi], in_last_i[gi]};
      end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop[gi]) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        if (push && !pop[gi]) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (!push && pop[gi]) begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end
    end

    assign head[gi]       = mem[rd_ptr_reg];
    assign head_valid[gi] = (count_reg != '0);
    assign head_col       = head[gi][DATA_W+1 +: COL_W];
    assign head_row       = head[gi][DATA_W+1+COL_W +: ROW_W];

    // Column first, then row, else deliver locally.
    always_comb begin
      dest[gi] = 2'd2;
      if (head_col != COL_W'(NI_COL)) begin
        dest[gi] = 2'd0;
      end else if (head_row != ROW_W'(NI_ROW)) begin
        dest[gi] = 2'd1;
      end
    end

    // Only the output this head is routed to can pop it, and only when that
    // output has granted this input.
    assign pop[gi] = head_valid[gi] && out_valid_o[dest[gi]] &&
                     out_ready_i[dest[gi]] && (grant[dest[gi]] == 2'(gi));
  end

  // -------------------------------------------------------------------------
  // Output arbiters
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_out
    logic               locked_reg;
    logic [1:0]         owner_reg;
    logic [1:0]         ptr_reg;
    logic [1:0]         sel;
    logic               any_req;
    logic               hs;
    logic [ENTRY_W-1:0] sel_entry;

    always_comb begin
      sel     = owner_reg;
      any_req = 1'b0;
      if (locked_reg) begin
        any_req = head_valid[owner_reg] && (dest[owner_reg] == 2'(gi));
      end else begin
        // Walk from the highest offset down so the nearest requester to
        // ptr_reg is the one left in sel.
        for (int k = 2; k >= 0; k--) begin
          if (head_valid[rr_idx(ptr_reg, k)] &&
              (dest[rr_idx(ptr_reg, k)] == 2'(gi))) begin
            sel     = rr_idx(ptr_reg, k);
            any_req = 1'b1;
          end
        end
      end
    end

    assign sel_entry       = head[sel];
    assign grant[gi]       = sel;
    assign out_valid_o[gi] = any_req;
    assign out_did_o[gi]   = sel_entry[DATA_W+1 +: DID_W];
    assign out_data_o[gi]  = sel_entry[1 +: DATA_W];
    assign out_last_o[gi]  = sel_entry[0];
    assign hs              = any_req && out_ready_i[gi];

    // The lock is taken as soon as a beat is presented, not only after it is
    // accepted: a stalled beat must not be replaced by a newly arriving
    // requester with higher round-robin priority.
    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        locked_reg <= 1'b0;
        owner_reg  <= 2'd0;
        ptr_reg    <= 2'd0;
      end else if (hs && sel_entry[0]) begin
        locked_reg <= 1'b0;
        ptr_reg    <= rr_idx(sel, 1);
      end else if (any_req) begin
        locked_reg <= 1'b1;
        owner_reg  <= sel;
      end
    end

`ifdef AXI_GRID_ROUTER_STATS_EN
    logic [31:0] beat_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        beat_cnt_reg  <= '0;
        stall_cnt_reg <= '0;
      end else begin
        if (hs) begin
          beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end
        if (any_req && !out_ready_i[gi]) begin
          stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
      end
    end

    assign beat_cnt_o[gi]  = beat_cnt_reg;
    assign stall_cnt_o[gi] = stall_cnt_reg;
`endif
  end

endmodule
